delayed_event_array: RTL and testbench
======================================

// Module: delayed_event_array
//
// PURPOSE
// Parametrised successor of the single delayed-event generator. CH independent
// channels, each armed by a start strobe with a runtime delay value. Each channel
// emits a one-clock on_event pulse after that delay, plus before/after level flags.
// Supports one-shot or periodic mode, retrigger and cancel. Used for power-up
// sequencing, deferred strobes and periodic ticks.
//
// PARAMETERS
// CH     4   number of independent channels (>=1)
// CNT_W  16  width of per-channel delay counter; max delay 2**CNT_W-1 cycles
//
// PORTS
// clk           in   1         clock
// rst           in   1         synchronous reset, active-high
// ena           in   1         count enable, common to all channels; 0 freezes counters
// start         in   CH        per-channel arm/retrigger strobe, sampled every clk
// cancel        in   CH        per-channel abort strobe
// delay         in   CH*CNT_W  per-channel delay, ch i at [i*CNT_W +: CNT_W]; latched on start
// periodic      in   CH        per-channel mode, latched on start: 0 one-shot, 1 periodic
// on_event      out  CH        one-clock pulse when the channel's delay expires
// before_event  out  CH        1 while the channel is armed and counting
// after_event   out  CH        1 from first on_event until next start/cancel/rst
// busy          out  1         OR of before_event
//
// BEHAVIOUR
// - All outputs registered. On rst (sampled high): every channel -> IDLE,
//   counter=0, on_event=0, before_event=0, after_event=0, busy=0.
// - Per-channel FSM, states IDLE, COUNT, DONE. Channels fully independent.
// - Per-edge priority: rst > cancel > start > counting.
// - cancel=1, any state: -> IDLE, counter=0, before=0, after=0, no on_event.
// - start=1 (no cancel), any state: latch delay and periodic.
//   Load counter=delay, -> COUNT, before=1, after=0.
//   Retrigger in COUNT discards the old count; no on_event for the old arm.
// - COUNT, ena=1: if counter==0, fire: on_event=1 next cycle, after=1.
//   One-shot: -> DONE, before=0.
//   Periodic: reload counter=latched delay, stay COUNT, before stays 1.
//   Otherwise counter-=1.
// - COUNT, ena=0: counter and state hold, no fire.
//   start and cancel are still honoured while ena=0.
// - Latency: start high in cycle 0, ena continuously 1 -> on_event high in
//   cycle D+1. D=0 gives on_event in cycle 1. Periodic period is D+1 cycles.
// - DONE: holds after=1, before=0 until start, cancel or rst. on_event fires once.
// - on_event is never high for 2 consecutive cycles unless periodic with D=0;
//   then it is continuously high while ena=1.
// - delay is sampled only on start; later delay changes do not affect a running count.
// - No arithmetic wrap: counter only decrements from the loaded value to 0.
//
// TESTING
// 1 rst, then start[0]=1 with delay0=5, one-shot: on_event[0] in cycle 6 only;
//   before[0]=1 in cycles 1..5; after[0]=1 from cycle 6; busy mirrors before[0].
// 2 delay=0 one-shot -> on_event in cycle 1. Periodic delay=3 -> on_event in
//   cycles 4, 8, 12, ...; after stays 1.
// 3 delay=10: ena=0 for 4 cycles mid-count -> on_event shifts from cycle 11 to 15.
//   Also check start/cancel are honoured during ena=0.
// 4 Retrigger at cycle 5 with delay=2 -> no pulse at 11, on_event in cycle 8.
//   Simultaneous start+cancel -> IDLE, no on_event.
// 5 All 4 channels: delays 0, 7, 255, 65535 (max) started together ->
//   pulses in cycles 1, 8, 256, 65536. Cancel ch2 at cycle 100 -> ch2 silent,
//   others unaffected.
// 6 rst asserted mid-count (cycle 3, delay=8) -> all outputs 0 next cycle and no
//   later on_event. Then start -> normal operation resumes.

Source files
------------

// File: rtl/delayed_event_array.sv
`default_nettype none
// ============================================================================
// Module   : delayed_event_array
// Purpose  : CH independent delayed-event channels. Each channel is armed by a
//            start strobe with its own delay and emits a one-clock on_event
//            pulse plus before/after level flags. Supports one-shot or
//            periodic mode, retrigger and cancel.
// Revision : 1.0 - initial release
// ============================================================================
module delayed_event_array #(
    parameter int CH    = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [CH-1:0]         start,
    input  logic [CH-1:0]         cancel,
    input  logic [CH*CNT_W-1:0]   delay,
    input  logic [CH-1:0]         periodic,
    output logic [CH-1:0]         on_event,
    output logic [CH-1:0]         before_event,
    output logic [CH-1:0]         after_event,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [CH-1:0] w_fire;
    logic [CH-1:0] w_before_nxt;
    logic [CH-1:0] w_after_nxt;

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            state_t           r_state, w_state_nxt;
            logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
            logic [CNT_W-1:0] r_dly, w_dly_nxt;
            logic             r_per, w_per_nxt;
            logic             w_fire_ch, w_before_ch, w_after_ch;
            logic [CNT_W-1:0] w_dly_in;

            assign w_dly_in        = delay[g*CNT_W +: CNT_W];
            assign w_fire[g]       = w_fire_ch;
            assign w_before_nxt[g] = w_before_ch;
            assign w_after_nxt[g]  = w_after_ch;

            // Channel state, counter and latched arm settings.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_dly   <= '0;
                    r_per   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_dly   <= w_dly_nxt;
                    r_per   <= w_per_nxt;
                end
            end

            // Next-state logic: cancel beats start beats counting. The start
            // edge itself counts as the first enabled cycle, so a delay of D
            // yields on_event D+1 cycles after the start cycle (D=0 fires at
            // once); periodic reloads use the full delay to give period D+1.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_dly_nxt   = r_dly;
                w_per_nxt   = r_per;
                w_fire_ch   = 1'b0;
                w_before_ch = before_event[g];
                w_after_ch  = after_event[g];

                if (cancel[g]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_before_ch = 1'b0;
                    w_after_ch  = 1'b0;
                end else if (start[g]) begin
                    w_dly_nxt  = w_dly_in;
                    w_per_nxt  = periodic[g];
                    w_after_ch = 1'b0;
                    if (ena && (w_dly_in == '0)) begin
                        w_fire_ch  = 1'b1;
                        w_after_ch = 1'b1;
                        w_cnt_nxt  = '0;
                        if (periodic[g]) begin
                            w_state_nxt = ST_COUNT;
                            w_before_ch = 1'b1;
                        end else begin
                            w_state_nxt = ST_DONE;
                            w_before_ch = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_COUNT;
                        w_before_ch = 1'b1;
                        w_cnt_nxt   = ena ? (w_dly_in - c_CNT_ONE) : w_dly_in;
                    end
                end else if ((r_state == ST_COUNT) && ena) begin
                    if (r_cnt == '0) begin
                        w_fire_ch  = 1'b1;
                        w_after_ch = 1'b1;
                        if (r_per) begin
                            w_cnt_nxt   = r_dly;
                            w_before_ch = 1'b1;
                        end else begin
                            w_state_nxt = ST_DONE;
                            w_before_ch = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    // Registered outputs; busy is derived from next-cycle before flags so it
    // lines up exactly with before_event.
    always_ff @(posedge clk) begin
        if (rst) begin
            on_event     <= '0;
            before_event <= '0;
            after_event  <= '0;
            busy         <= 1'b0;
        end else begin
            on_event     <= w_fire;
            before_event <= w_before_nxt;
            after_event  <= w_after_nxt;
            busy         <= |w_before_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delayed_event_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_delayed_event_array
// Purpose  : Directed self-checking bench for delayed_event_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delayed_event_array;

    localparam int CH    = 4;
    localparam int CNT_W = 16;

    logic                clk;
    logic                rst;
    logic                ena;
    logic [CH-1:0]       start;
    logic [CH-1:0]       cancel;
    logic [CH*CNT_W-1:0] delay;
    logic [CH-1:0]       periodic;
    logic [CH-1:0]       on_event;
    logic [CH-1:0]       before_event;
    logic [CH-1:0]       after_event;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;

    delayed_event_array #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start        (start),
        .cancel       (cancel),
        .delay        (delay),
        .periodic     (periodic),
        .on_event     (on_event),
        .before_event (before_event),
        .after_event  (after_event),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; start = '0; cancel = '0; delay = '0; periodic = '0;
        step(); step();
        // Reset state
        chk("rst_on",     on_event,     '0);
        chk("rst_before", before_event, '0);
        chk("rst_after",  after_event,  '0);
        chk("rst_busy",   busy,         '0);
        rst = 1'b0;
        ena = 1'b1;
        step();

        // 1: one-shot delay 5 on ch0 -> pulse in cycle 6
        start = 4'b0001; delay[15:0] = 16'd5; periodic = '0;
        step(); start = '0;
        for (int c = 1; c <= 7; c++) begin
            chk("t1_on",     on_event[0],     c == 6);
            chk("t1_before", before_event[0], c <= 5);
            chk("t1_after",  after_event[0],  c >= 6);
            chk("t1_busy",   busy,            c <= 5);
            step();
        end

        // 2a: one-shot delay 0 -> pulse in cycle 1
        start = 4'b0001; delay[15:0] = 16'd0;
        step(); start = '0;
        chk("t2a_on1",    on_event[0],     1'b1);
        chk("t2a_before", before_event[0], 1'b0);
        chk("t2a_after1", after_event[0],  1'b1);
        step();
        chk("t2a_on2",    on_event[0],     1'b0);
        chk("t2a_after2", after_event[0],  1'b1);

        // 2b: periodic delay 3 -> pulses in cycles 4, 8, 12
        start = 4'b0001; delay[15:0] = 16'd3; periodic = 4'b0001;
        step(); start = '0; periodic = '0;
        for (int c = 1; c <= 13; c++) begin
            chk("t2b_on",     on_event[0],     (c % 4) == 0);
            chk("t2b_before", before_event[0], 1'b1);
            chk("t2b_after",  after_event[0],  c >= 4);
            step();
        end
        cancel = 4'b0001;
        step(); cancel = '0;
        chk("t2b_cx_on",     on_event[0],     1'b0);
        chk("t2b_cx_before", before_event[0], 1'b0);
        chk("t2b_cx_after",  after_event[0],  1'b0);
        chk("t2b_cx_busy",   busy,            1'b0);

        // 3: delay 10 with ena low in cycles 3..6 -> pulse moves to cycle 15
        start = 4'b0001; delay[15:0] = 16'd10;
        step(); start = '0;
        for (int c = 1; c <= 16; c++) begin
            chk("t3_on",     on_event[0],     c == 15);
            chk("t3_before", before_event[0], c <= 14);
            ena = !(c >= 3 && c <= 6);
            step();
        end
        ena = 1'b1;
        // start and cancel honoured while ena is low
        ena = 1'b0;
        start = 4'b0010; delay[31:16] = 16'd2;
        step(); start = '0;
        chk("t3_ena0_start", before_event[1], 1'b1);
        step();
        chk("t3_ena0_hold_b", before_event[1], 1'b1);
        chk("t3_ena0_hold_e", on_event[1],     1'b0);
        cancel = 4'b0010;
        step(); cancel = '0;
        chk("t3_ena0_cx_b", before_event[1], 1'b0);
        chk("t3_ena0_cx_a", after_event[1],  1'b0);
        ena = 1'b1;

        // 4: delay 10, retrigger at cycle 5 with delay 2 -> pulse in cycle 8 only
        start = 4'b0001; delay[15:0] = 16'd10;
        step(); start = '0;
        for (int c = 1; c <= 12; c++) begin
            chk("t4_on",     on_event[0],     c == 8);
            chk("t4_before", before_event[0], c <= 7);
            if (c == 5) begin
                start = 4'b0001; delay[15:0] = 16'd2;
            end else begin
                start = '0;
            end
            step();
        end
        start = '0;
        // simultaneous start+cancel (delay 0 would otherwise fire at once)
        start = 4'b0001; cancel = 4'b0001; delay[15:0] = 16'd0;
        step(); start = '0; cancel = '0;
        chk("t4_sc_on",     on_event[0],     1'b0);
        chk("t4_sc_before", before_event[0], 1'b0);
        chk("t4_sc_after",  after_event[0],  1'b0);
        step();
        chk("t4_sc_on2",    on_event[0],     1'b0);

        // 5: all channels, delays 0/7/255/65535, ch2 cancelled at cycle 100
        start = 4'b1111; periodic = '0;
        delay = {16'd65535, 16'd255, 16'd7, 16'd0};
        step(); start = '0;
        for (int c = 1; c <= 65537; c++) begin
            chk("t5_on", on_event, {c == 65536, 1'b0, c == 8, c == 1});
            if (c == 1 || c == 8 || c == 99 || c == 101 || c == 256 || c >= 65535) begin
                chk("t5_before", before_event, {c <= 65535, c <= 100, c <= 7, 1'b0});
                chk("t5_busy",   busy,         c <= 65535);
            end
            cancel = (c == 100) ? 4'b0100 : 4'b0000;
            step();
        end
        cancel = '0;
        chk("t5_after", after_event, 4'b1011);

        // 6: reset mid-count (cycle 3, delay 8) then resume
        start = 4'b0001; delay[15:0] = 16'd8;
        step(); start = '0;
        chk("t6_before1", before_event[0], 1'b1);
        step();
        chk("t6_before2", before_event[0], 1'b1);
        step();
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t6_rst_on",     on_event,     '0);
        chk("t6_rst_before", before_event, '0);
        chk("t6_rst_after",  after_event,  '0);
        chk("t6_rst_busy",   busy,         '0);
        for (int c = 5; c <= 12; c++) begin
            chk("t6_silent", on_event[0], 1'b0);
            step();
        end
        start = 4'b0001; delay[15:0] = 16'd1;
        step(); start = '0;
        chk("t6_res_c1", on_event[0], 1'b0);
        step();
        chk("t6_res_c2", on_event[0], 1'b1);
        chk("t6_res_after", after_event[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
